uart_tx: RTL

- Serial transmitter for the core's UART_TX pin; the transmit-side counterpart of the receiver that samples UART_RX.
- Accepts bytes from the CPU/IO side over a valid/ready handshake and buffers them in a small FIFO.
- Serializes each byte as an asynchronous frame (start, data LSB-first, optional parity, stop) at a runtime-programmable bit period.
- Honours hardware flow control (cts_n) at frame boundaries.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_fifo.sv | 60 ++++++
 rtl/uart_tx.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    localparam int DIV_MIN = 2;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with show-ahead read data; pushes when full and pops when empty are ignored.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               wdata,
    input  logic                     pop,
    output logic [7:0]               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem[rptr_q];

    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
        rptr_d  = do_pop  ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: buffered bytes serialized as start/data/parity/stop frames, gated by cts_n at frame start.
module uart_tx
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int DIV_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DIV_W-1:0]              divisor,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          cts_n,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam parity_e PAR_MODE = parity_e'(PARITY);

    tx_state_e        state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic             stop_q, stop_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             tx_q, tx_d;

    logic       fifo_pop, fifo_full, fifo_empty;
    logic [7:0] fifo_rdata;
    logic       bit_end, start_ok;

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_valid),
        .wdata (in_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign in_ready = !fifo_full;
    assign busy     = (state_q != ST_IDLE) || !fifo_empty;
    assign tx       = tx_q;
    assign bit_end  = (cnt_q == div_q - DIV_W'(1));
    assign start_ok = !fifo_empty && !cts_n;

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        cnt_d    = (state_q == ST_IDLE || bit_end) ? '0 : cnt_q + DIV_W'(1);
        bit_d    = bit_q;
        stop_d   = stop_q;
        shift_d  = shift_q;
        par_d    = par_q;
        tx_d     = tx_q;
        fifo_pop = 1'b0;

        unique case (state_q)
            ST_IDLE: ;
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) begin
                        stop_d = 1'b0;
                        if (PAR_MODE != PAR_NONE) begin
                            state_d = ST_PARITY;
                            tx_d    = par_q;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    stop_d  = 1'b0;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (int'(stop_q) == STOP_BITS - 1) begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Frame start, either from idle or straight out of the last stop bit.
        if ((state_q == ST_IDLE || state_d == ST_IDLE) && start_ok) begin
            fifo_pop = 1'b1;
            state_d  = ST_START;
            shift_d  = fifo_rdata;
            par_d    = (PAR_MODE == PAR_ODD) ? ~^fifo_rdata : ^fifo_rdata;
            div_d    = (divisor < DIV_W'(DIV_MIN)) ? DIV_W'(DIV_MIN) : divisor;
            cnt_d    = '0;
            tx_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            div_q   <= DIV_W'(DIV_MIN);
            cnt_q   <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
        end
    end

endmodule
